drum_mem_responder: RTL and testbench



---
 rtl/drum_mem_pkg.sv | 39 +++
 rtl/drum_word_store.sv | 35 +++
 rtl/drum_mem_responder.sv | 132 +++++++++++++
 tb/tb_drum_mem_responder.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drum_mem_pkg.sv
// Shared types and defaults for the drum memory responder.
package drum_mem_pkg;

  localparam int unsigned DEF_ADDR_WIDTH  = 11;
  localparam int unsigned DEF_DATA_WIDTH  = 31;
  localparam int unsigned DEF_SECTOR_BITS = 5;

  // Responder states; SEEK waits for the drum, XFER is the single transfer cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEEK = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_t;

  // Operation type latched at request acceptance.
  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // Write wins when both request lines are high.
  function automatic op_t pick_op(input logic write_req);
    return write_req ? OP_WRITE : OP_READ;
  endfunction

  // Request line belonging to the operation currently being served.
  function automatic logic served_line(input op_t op, input logic read_req,
                                       input logic write_req);
    return (op == OP_WRITE) ? write_req : read_req;
  endfunction

  // Request line of the opposite type, the only one that may start a new access from DONE.
  function automatic logic other_line(input op_t op, input logic read_req,
                                      input logic write_req);
    return (op == OP_WRITE) ? read_req : write_req;
  endfunction

endpackage

// File: rtl/drum_word_store.sv
// Single-port synchronous word store behind the drum responder.
module drum_word_store #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 31
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Array contents are never reset; a write lands on the edge that ends the write cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read port only updates on a read, so the last read word is held in between.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/drum_mem_responder.sv
// Rotating-drum memory responder: waits for the addressed sector, moves one word,
// then pulses mem_finish for one cycle.
module drum_mem_responder
  import drum_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned SECTOR_BITS = DEF_SECTOR_BITS
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   read_enable,
  input  logic                   write_enable,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [DATA_WIDTH-1:0]  write_data,
  output logic [DATA_WIDTH-1:0]  read_data,
  output logic                   mem_finish,
  output logic                   busy,
  output logic [SECTOR_BITS-1:0] sector
);

  state_t                state;
  op_t                   op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic accept_c;
  op_t  accept_op_c;
  logic served_c;
  logic accept_hit_c;
  logic seek_hit_c;
  logic store_we_c;
  logic store_re_c;

  // Free-running drum position, wraps naturally at 2^SECTOR_BITS.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sector <= '0;
    end else begin
      sector <= sector + SECTOR_BITS'(1);
    end
  end

  // Request decode: IDLE takes either line, DONE only the line not being served.
  always_comb begin
    accept_c    = 1'b0;
    accept_op_c = OP_READ;
    served_c    = served_line(op_q, read_enable, write_enable);
    case (state)
      IDLE: begin
        accept_c    = write_enable | read_enable;
        accept_op_c = pick_op(write_enable);
      end
      DONE: begin
        accept_c    = other_line(op_q, read_enable, write_enable);
        accept_op_c = (op_q == OP_WRITE) ? OP_READ : OP_WRITE;
      end
      default: begin
        accept_c    = 1'b0;
        accept_op_c = OP_READ;
      end
    endcase
  end

  // Sector match against the incoming address (at accept) and the latched one (while seeking).
  assign accept_hit_c = (sector == addr[SECTOR_BITS-1:0]);
  assign seek_hit_c   = (sector == addr_q[SECTOR_BITS-1:0]);

  // The store is only touched during the single XFER cycle.
  assign store_we_c = (state == XFER) && (op_q == OP_WRITE);
  assign store_re_c = (state == XFER) && (op_q == OP_READ);

  // Access sequencer with registered busy/mem_finish.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      op_q       <= OP_READ;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy       <= 1'b0;
      mem_finish <= 1'b0;
    end else begin
      mem_finish <= 1'b0;
      if (accept_c) begin
        op_q    <= accept_op_c;
        addr_q  <= addr;
        wdata_q <= write_data;
        busy    <= 1'b1;
        state   <= accept_hit_c ? XFER : SEEK;
      end else begin
        case (state)
          SEEK: begin
            if (!served_c) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else if (seek_hit_c) begin
              state <= XFER;
            end
          end
          XFER: begin
            state      <= DONE;
            busy       <= 1'b0;
            mem_finish <= 1'b1;
          end
          DONE: begin
            if (!served_c) begin
              state <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // Word store; its read register doubles as the held read_data output.
  drum_word_store #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_store (
    .clk   (clk),
    .rst_n (resetn),
    .we    (store_we_c),
    .re    (store_re_c),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (read_data)
  );

endmodule

// File: tb/tb_drum_mem_responder.sv
// Self-checking bench for drum_mem_responder.
module tb_drum_mem_responder;

  localparam int unsigned AW   = 11;
  localparam int unsigned DW   = 31;
  localparam int unsigned SB   = 5;
  localparam int          NSEC = 32;

  logic          clk          = 1'b0;
  logic          resetn       = 1'b1;
  logic          read_enable  = 1'b0;
  logic          write_enable = 1'b0;
  logic [AW-1:0] addr         = '0;
  logic [DW-1:0] write_data   = '0;
  logic [DW-1:0] read_data;
  logic          mem_finish;
  logic          busy;
  logic [SB-1:0] sector;

  drum_mem_responder #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .SECTOR_BITS(SB)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .read_enable (read_enable),
    .write_enable(write_enable),
    .addr        (addr),
    .write_data  (write_data),
    .read_data   (read_data),
    .mem_finish  (mem_finish),
    .busy        (busy),
    .sector      (sector)
  );

  always #5 clk = ~clk;

  // Cycle index since reset release: cycle k follows the k-th rising edge.
  int cyc;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] last_rd = '0;

  typedef struct {
    int          acc;
    int          fin;
    bit          rd;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit            wr;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [DW-1:0] exp_rd;
  } vec_t;
  vec_t vecs[8];

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sector(input int v);
    for (int i = 0; i < NSEC + 2 && (cyc % NSEC) != v; i++) tick();
  endtask

  // Expected completion: accept at next edge, d = (t - s) mod 32, finish at acc + d + 1.
  task automatic push(input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] data);
    exp_t e;
    int   s;
    int   d;
    s      = cyc % NSEC;
    d      = (int'(a[SB-1:0]) - s + NSEC) % NSEC;
    e.acc  = cyc + 1;
    e.fin  = e.acc + d + 1;
    e.rd   = rd;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic drive(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [DW-1:0] exp_rd);
    write_enable = wr;
    read_enable  = !wr;
    addr         = a;
    write_data   = wd;
    push(!wr, a, exp_rd);
  endtask

  task automatic wait_fin(input string name);
    bit   seen    = 0;
    bit   busy_ok = 1;
    exp_t e;
    e = sb[0];
    for (int i = 0; i < NSEC + 8 && !seen; i++) begin
      tick();
      if (i == 0) begin
        addr       = AW'($urandom);
        write_data = DW'($urandom);
      end
      if (busy !== ((cyc >= e.acc && cyc < e.fin) ? 1'b1 : 1'b0)) busy_ok = 0;
      if (mem_finish === 1'b1) seen = 1;
    end
    chk({name, "_finish_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      void'(sb.pop_front());
      chk({name, "_finish_cycle"}, 64'(cyc), 64'(e.fin));
      chk({name, "_busy"}, 64'(busy_ok), 64'd1);
      chk({name, "_sector"}, 64'(sector), 64'(cyc % NSEC));
      if (e.rd) begin
        chk({name, "_read_data"}, 64'(read_data), 64'(e.data));
        last_rd = e.data;
      end else begin
        chk({name, "_read_data_held"}, 64'(read_data), 64'(last_rd));
      end
    end
  endtask

  task automatic release_req(input string name, input int hold);
    int bad = 0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (mem_finish !== 1'b0 || busy !== 1'b0) bad++;
    end
    read_enable  = 1'b0;
    write_enable = 1'b0;
    tick();
    if (mem_finish !== 1'b0 || busy !== 1'b0) bad++;
    chk({name, "_no_retrigger"}, 64'(bad), 64'd0);
  endtask

  task automatic do_txn(input string name, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd, input int hold);
    drive(wr, a, wd, exp_rd);
    wait_fin(name);
    release_req(name, hold);
  endtask

  task automatic watch_quiet(input string name, input int n);
    int hits = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (mem_finish !== 1'b0) hits++;
    end
    chk(name, 64'(hits), 64'd0);
  endtask

  task automatic apply_reset(input string name);
    read_enable  = 1'b0;
    write_enable = 1'b0;
    resetn       = 1'b0;
    #1;
    chk({name, "_sector"}, 64'(sector), 64'd0);
    chk({name, "_busy"}, 64'(busy), 64'd0);
    chk({name, "_finish"}, 64'(mem_finish), 64'd0);
    chk({name, "_read_data"}, 64'(read_data), 64'd0);
    @(negedge clk);
    resetn  = 1'b1;
    last_rd = '0;
    sb.delete();
  endtask

  initial begin
    int            c;
    int            low;
    logic [AW-1:0] a;

    vecs[0] = '{wr: 1'b1, a: 11'h010, wd: 31'h0ABCDEF,  exp_rd: 31'h0};
    vecs[1] = '{wr: 1'b1, a: 11'h7FF, wd: 31'h7FFFFFFF, exp_rd: 31'h0};
    vecs[2] = '{wr: 1'b1, a: 11'h000, wd: 31'h2AAAAAAA, exp_rd: 31'h0};
    vecs[3] = '{wr: 1'b0, a: 11'h010, wd: 31'h0,        exp_rd: 31'h0ABCDEF};
    vecs[4] = '{wr: 1'b0, a: 11'h7FF, wd: 31'h0,        exp_rd: 31'h7FFFFFFF};
    vecs[5] = '{wr: 1'b0, a: 11'h000, wd: 31'h0,        exp_rd: 31'h2AAAAAAA};
    vecs[6] = '{wr: 1'b1, a: 11'h010, wd: 31'h0000001,  exp_rd: 31'h0};
    vecs[7] = '{wr: 1'b0, a: 11'h010, wd: 31'h0,        exp_rd: 31'h0000001};

    #2;
    apply_reset("reset0");
    tick();
    chk("sector_first_edge", 64'(sector), 64'd1);

    // Read latency from a known drum position.
    do_txn("wr5", 1'b1, 11'd5, 31'h1234567, 31'h0, 0);
    apply_reset("reset1");
    do_txn("rd5_latency", 1'b0, 11'd5, 31'h0, 31'h1234567, 0);

    for (int i = 0; i < 8; i++) begin
      do_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].exp_rd, 0);
    end

    // Zero wait write, wrap-around read, zero wait read.
    low = cyc % NSEC;
    a   = {6'h2A, SB'(low)};
    c   = cyc;
    drive(1'b1, a, 31'h0C0FFEE, 31'h0);
    wait_fin("zero_wait_wr");
    chk("zero_wait_wr_latency", 64'(cyc - c), 64'd2);
    release_req("zero_wait_wr", 0);
    wait_sector((low + 1) % NSEC);
    c = cyc;
    drive(1'b0, a, 31'h0, 31'h0C0FFEE);
    wait_fin("wrap_rd");
    chk("wrap_rd_latency", 64'(cyc - c), 64'd33);
    release_req("wrap_rd", 0);
    wait_sector(low);
    c = cyc;
    drive(1'b0, a, 31'h0, 31'h0C0FFEE);
    wait_fin("zero_wait_rd");
    chk("zero_wait_rd_latency", 64'(cyc - c), 64'd2);
    release_req("zero_wait_rd", 0);

    // Write then read with no gap, read accepted straight from DONE.
    drive(1'b1, 11'd3, 31'h3333333, 31'h0);
    wait_fin("b2b_wr");
    addr       = 11'd3;
    write_data = 31'h7777777;
    tick();
    chk("b2b_done_busy", 64'(busy), 64'd0);
    chk("b2b_done_finish", 64'(mem_finish), 64'd0);
    write_enable = 1'b0;
    read_enable  = 1'b1;
    addr         = 11'd3;
    push(1'b1, 11'd3, 31'h3333333);
    wait_fin("b2b_rd");
    release_req("b2b_rd", 0);

    // Hold the request past mem_finish; then a fresh read proves the return to IDLE.
    do_txn("hold_rd3", 1'b0, 11'd3, 31'h0, 31'h3333333, 2);
    do_txn("after_hold_rd5", 1'b0, 11'd5, 31'h0, 31'h1234567, 0);

    // Read aborted during SEEK.
    a = {6'h11, SB'((cyc + 20) % NSEC)};
    read_enable = 1'b1;
    addr        = a;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("abort_rd_busy%0d", i), 64'(busy), 64'd1);
    end
    read_enable = 1'b0;
    tick();
    chk("abort_rd_idle", 64'(busy), 64'd0);
    watch_quiet("abort_rd_no_finish", NSEC + 4);

    // Write aborted during SEEK leaves the array untouched.
    wait_sector(10);
    write_enable = 1'b1;
    addr         = 11'd5;
    write_data   = 31'h7654321;
    repeat (4) tick();
    chk("abort_wr_busy", 64'(busy), 64'd1);
    write_enable = 1'b0;
    watch_quiet("abort_wr_no_finish", NSEC + 4);
    do_txn("abort_wr_readback", 1'b0, 11'd5, 31'h0, 31'h1234567, 0);

    // Both lines high in IDLE: write wins, read_data keeps the previous read.
    write_enable = 1'b1;
    read_enable  = 1'b1;
    addr         = 11'h123;
    write_data   = 31'h3C3C3C3;
    push(1'b0, 11'h123, 31'h0);
    tick();
    read_enable = 1'b0;
    wait_fin("prio_wr");
    release_req("prio_wr", 0);
    do_txn("prio_readback", 1'b0, 11'h123, 31'h0, 31'h3C3C3C3, 0);

    // Reset during SEEK of a write to address 9.
    do_txn("wr9", 1'b1, 11'd9, 31'h0000999, 31'h0, 0);
    do_txn("rd9", 1'b0, 11'd9, 31'h0, 31'h0000999, 0);
    wait_sector(10);
    write_enable = 1'b1;
    addr         = 11'd9;
    write_data   = 31'h5A5A5A5;
    repeat (3) tick();
    chk("mid_reset_seek_busy", 64'(busy), 64'd1);
    apply_reset("mid_reset");
    chk("mid_reset_sector_restart", 64'(sector), 64'd0);
    tick();
    chk("mid_reset_sector_one", 64'(sector), 64'd1);
    do_txn("mid_reset_rd9", 1'b0, 11'd9, 31'h0, 31'h0000999, 0);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
